// File: rtl/can_reg_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  can_reg_arb_pkg
//  Shared types and default bounds for the CAN register write arbiter.
//  Revision: 1.0
// ============================================================================
package can_reg_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_WR_HOST = 2'd1,
    ARB_WR_CORE = 2'd2
  } arb_state_e;

  localparam int ARB_ADDR_WIDTH_DEFAULT = 8;
  localparam int ARB_DATA_WIDTH_DEFAULT = 8;
  localparam int ARB_LOCK_LO_DEFAULT    = 4;
  localparam int ARB_LOCK_HI_DEFAULT    = 7;

endpackage
`default_nettype wire

// File: rtl/can_reg_write_arbiter_if.sv
`default_nettype none
// ============================================================================
//  can_reg_write_arbiter_if
//  Host/core request buses and the register-bank write port of the arbiter.
//  Revision: 1.0
// ============================================================================
interface can_reg_write_arbiter_if
  import can_reg_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = ARB_ADDR_WIDTH_DEFAULT,
  parameter int DATA_WIDTH = ARB_DATA_WIDTH_DEFAULT
);

  logic                  reset_mode;
  logic                  host_req;
  logic [ADDR_WIDTH-1:0] host_addr;
  logic [DATA_WIDTH-1:0] host_wdata;
  logic                  host_ack;
  logic                  host_err;
  logic                  core_req;
  logic [ADDR_WIDTH-1:0] core_addr;
  logic [DATA_WIDTH-1:0] core_wdata;
  logic                  core_ack;
  logic                  reg_we;
  logic [ADDR_WIDTH-1:0] reg_addr;
  logic [DATA_WIDTH-1:0] reg_wdata;

  // Requester side (host interface, CAN core, controller mode).
  modport master (
    output reset_mode, host_req, host_addr, host_wdata,
    output core_req, core_addr, core_wdata,
    input  host_ack, host_err, core_ack, reg_we, reg_addr, reg_wdata
  );

  // Arbiter side.
  modport slave (
    input  reset_mode, host_req, host_addr, host_wdata,
    input  core_req, core_addr, core_wdata,
    output host_ack, host_err, core_ack, reg_we, reg_addr, reg_wdata
  );

endinterface
`default_nettype wire

// File: rtl/can_reg_write_arbiter.sv
`default_nettype none
// ============================================================================
//  can_reg_write_arbiter
//  Core-priority, burst-bounded arbiter for the CAN register bank write port.
//  Revision: 1.0
// ============================================================================
module can_reg_write_arbiter
  import can_reg_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = ARB_ADDR_WIDTH_DEFAULT,
  parameter int DATA_WIDTH     = ARB_DATA_WIDTH_DEFAULT,
  parameter int CORE_BURST_MAX = 4,
  parameter int LOCK_LO        = ARB_LOCK_LO_DEFAULT,
  parameter int LOCK_HI        = ARB_LOCK_HI_DEFAULT
) (
  input  wire logic              clk,
  input  wire logic              rst,
  can_reg_write_arbiter_if.slave bus
);

  localparam int                    c_STREAK_W   = $clog2(CORE_BURST_MAX + 1);
  localparam logic [c_STREAK_W-1:0] c_STREAK_MAX = c_STREAK_W'(CORE_BURST_MAX);
  localparam logic [ADDR_WIDTH-1:0] c_LOCK_LO    = ADDR_WIDTH'(LOCK_LO);
  localparam logic [ADDR_WIDTH-1:0] c_LOCK_HI    = ADDR_WIDTH'(LOCK_HI);

  arb_state_e            state_q, state_d;
  logic [c_STREAK_W-1:0] streak_q, streak_d;
  logic                  reg_we_q, reg_we_d;
  logic                  host_ack_q, host_ack_d;
  logic                  host_err_q, host_err_d;
  logic                  core_ack_q, core_ack_d;
  logic [ADDR_WIDTH-1:0] reg_addr_q, reg_addr_d;
  logic [DATA_WIDTH-1:0] reg_wdata_q, reg_wdata_d;
  logic                  w_host_locked;
  logic                  w_host_forced;

  assign w_host_locked = (bus.host_addr >= c_LOCK_LO) && (bus.host_addr <= c_LOCK_HI)
                         && !bus.reset_mode;
  assign w_host_forced = bus.host_req && (streak_q == c_STREAK_MAX);

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    reg_we_d    = 1'b0;
    host_ack_d  = 1'b0;
    host_err_d  = 1'b0;
    core_ack_d  = 1'b0;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;

    case (state_q)
      ARB_IDLE: begin
        if (!bus.host_req) streak_d = '0;
        if (bus.core_req && !w_host_forced) begin
          state_d     = ARB_WR_CORE;
          reg_we_d    = 1'b1;
          core_ack_d  = 1'b1;
          reg_addr_d  = bus.core_addr;
          reg_wdata_d = bus.core_wdata;
        end else if (bus.host_req) begin
          state_d    = ARB_WR_HOST;
          host_ack_d = 1'b1;
          // A refused write leaves the bank address/data untouched.
          if (w_host_locked) begin
            host_err_d = 1'b1;
          end else begin
            reg_we_d    = 1'b1;
            reg_addr_d  = bus.host_addr;
            reg_wdata_d = bus.host_wdata;
          end
        end
      end
      ARB_WR_CORE: begin
        state_d = ARB_IDLE;
        if (streak_q != c_STREAK_MAX) streak_d = streak_q + 1'b1;
      end
      ARB_WR_HOST: begin
        state_d  = ARB_IDLE;
        streak_d = '0;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      streak_q    <= '0;
      reg_we_q    <= 1'b0;
      host_ack_q  <= 1'b0;
      host_err_q  <= 1'b0;
      core_ack_q  <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      reg_we_q    <= reg_we_d;
      host_ack_q  <= host_ack_d;
      host_err_q  <= host_err_d;
      core_ack_q  <= core_ack_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
    end
  end

  // Reset arriving during a WR cycle must drop the write, so the pulses are masked by rst.
  assign bus.reg_we    = reg_we_q   & ~rst;
  assign bus.host_ack  = host_ack_q & ~rst;
  assign bus.host_err  = host_err_q & ~rst;
  assign bus.core_ack  = core_ack_q & ~rst;
  assign bus.reg_addr  = reg_addr_q;
  assign bus.reg_wdata = reg_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_can_reg_write_arbiter.sv
`default_nettype none
// ============================================================================
//  tb_can_reg_write_arbiter
//  Directed self-checking bench for can_reg_write_arbiter.
//  Revision: 1.0
// ============================================================================
module tb_can_reg_write_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  // flags = {reg_we, host_ack, host_err, core_ack}
  localparam logic [3:0] F_NONE     = 4'b0000;
  localparam logic [3:0] F_HOST_WR  = 4'b1100;
  localparam logic [3:0] F_HOST_ERR = 4'b0110;
  localparam logic [3:0] F_CORE     = 4'b1001;

  can_reg_write_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

  can_reg_write_arbiter #(
    .ADDR_WIDTH    (8),
    .DATA_WIDTH    (8),
    .CORE_BURST_MAX(4),
    .LOCK_LO       (4),
    .LOCK_HI       (7)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [3:0] flags;
  assign flags = {bus.reg_we, bus.host_ack, bus.host_err, bus.core_ack};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst            = 1'b1;
    bus.reset_mode = 1'b0;
    bus.host_req   = 1'b0;
    bus.host_addr  = 8'h00;
    bus.host_wdata = 8'h00;
    bus.core_req   = 1'b0;
    bus.core_addr  = 8'h00;
    bus.core_wdata = 8'h00;
    step();
    step();
    rst = 1'b0;
    step();
    n_tests++;
    if (flags !== F_NONE) begin
      n_fail++; $display("FAIL reset_flags: got %b expected %b", flags, F_NONE);
    end
    n_tests++;
    if ({bus.reg_addr, bus.reg_wdata} !== 16'h0000) begin
      n_fail++; $display("FAIL reset_addr_data: got %h expected 0000", {bus.reg_addr, bus.reg_wdata});
    end
  endtask

  task automatic test_host_only();
    bus.host_req   = 1'b1;
    bus.host_addr  = 8'h10;
    bus.host_wdata = 8'hA5;
    step();
    n_tests++;
    if (flags !== F_HOST_WR) begin
      n_fail++; $display("FAIL host_flags: got %b expected %b", flags, F_HOST_WR);
    end
    n_tests++;
    if ({bus.reg_addr, bus.reg_wdata} !== 16'h10A5) begin
      n_fail++; $display("FAIL host_addr_data: got %h expected 10a5", {bus.reg_addr, bus.reg_wdata});
    end
    bus.host_req = 1'b0;
    step();
    n_tests++;
    if (flags !== F_NONE) begin
      n_fail++; $display("FAIL host_pulse_width: got %b expected %b", flags, F_NONE);
    end
  endtask

  task automatic test_lock();
    logic [7:0] la [4];
    logic       le [4];
    la = '{8'h03, 8'h04, 8'h07, 8'h08};
    le = '{1'b0, 1'b1, 1'b1, 1'b0};
    bus.reset_mode = 1'b0;
    bus.host_req   = 1'b1;
    bus.host_addr  = 8'h05;
    bus.host_wdata = 8'h3C;
    step();
    n_tests++;
    if (flags !== F_HOST_ERR) begin
      n_fail++; $display("FAIL lock_refused: got %b expected %b", flags, F_HOST_ERR);
    end
    n_tests++;
    if ({bus.reg_addr, bus.reg_wdata} !== 16'h10A5) begin
      n_fail++; $display("FAIL lock_hold: got %h expected 10a5", {bus.reg_addr, bus.reg_wdata});
    end
    bus.host_req = 1'b0;
    step();
    bus.reset_mode = 1'b1;
    bus.host_req   = 1'b1;
    step();
    bus.reset_mode = 1'b0;
    n_tests++;
    if (flags !== F_HOST_WR || {bus.reg_addr, bus.reg_wdata} !== 16'h053C) begin
      n_fail++; $display("FAIL lock_reset_mode: got %b/%h expected %b/053c",
                         flags, {bus.reg_addr, bus.reg_wdata}, F_HOST_WR);
    end
    bus.host_req = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      bus.host_addr = la[i];
      bus.host_req  = 1'b1;
      step();
      n_tests++;
      if (flags !== (le[i] ? F_HOST_ERR : F_HOST_WR)) begin
        n_fail++; $display("FAIL lock_bound addr %h: got %b expected %b",
                           la[i], flags, le[i] ? F_HOST_ERR : F_HOST_WR);
      end
      bus.host_req = 1'b0;
      step();
    end
  endtask

  task automatic test_contention();
    logic [3:0] exp;
    bus.core_req   = 1'b1;
    bus.core_addr  = 8'h21;
    bus.core_wdata = 8'hC1;
    bus.host_req   = 1'b1;
    bus.host_addr  = 8'h30;
    bus.host_wdata = 8'h77;
    for (int g = 0; g < 10; g++) begin
      exp = (g == 4 || g == 9) ? F_HOST_WR : F_CORE;
      step();
      n_tests++;
      if (flags !== exp) begin
        n_fail++; $display("FAIL contention_grant %0d: got %b expected %b", g, flags, exp);
      end
      n_tests++;
      if (bus.reg_addr !== ((g == 4 || g == 9) ? 8'h30 : 8'h21)) begin
        n_fail++; $display("FAIL contention_addr %0d: got %h", g, bus.reg_addr);
      end
      step();
      n_tests++;
      if (flags !== F_NONE) begin
        n_fail++; $display("FAIL contention_gap %0d: got %b expected %b", g, flags, F_NONE);
      end
    end
    bus.core_req = 1'b0;
    bus.host_req = 1'b0;
    step();
  endtask

  task automatic test_simultaneous();
    bus.core_req   = 1'b1;
    bus.core_addr  = 8'h2A;
    bus.core_wdata = 8'h5A;
    bus.host_req   = 1'b1;
    bus.host_addr  = 8'h40;
    bus.host_wdata = 8'h44;
    step();
    n_tests++;
    if (flags !== F_CORE || bus.reg_addr !== 8'h2A) begin
      n_fail++; $display("FAIL simul_core_first: got %b/%h expected %b/2a", flags, bus.reg_addr, F_CORE);
    end
    bus.core_req = 1'b0;
    step();
    step();
    n_tests++;
    if (flags !== F_HOST_WR || {bus.reg_addr, bus.reg_wdata} !== 16'h4044) begin
      n_fail++; $display("FAIL simul_host_second: got %b/%h expected %b/4044",
                         flags, {bus.reg_addr, bus.reg_wdata}, F_HOST_WR);
    end
    bus.host_req = 1'b0;
    step();
  endtask

  task automatic test_rst_in_write();
    bus.host_req   = 1'b1;
    bus.host_addr  = 8'h11;
    bus.host_wdata = 8'h22;
    step();
    rst = 1'b1;
    #1;
    n_tests++;
    if (flags !== F_NONE) begin
      n_fail++; $display("FAIL rst_drop_write: got %b expected %b", flags, F_NONE);
    end
    step();
    n_tests++;
    if (flags !== F_NONE || {bus.reg_addr, bus.reg_wdata} !== 16'h0000) begin
      n_fail++; $display("FAIL rst_outputs: got %b/%h expected 0000/0000",
                         flags, {bus.reg_addr, bus.reg_wdata});
    end
    rst = 1'b0;
    step();
    n_tests++;
    if (flags !== F_HOST_WR || {bus.reg_addr, bus.reg_wdata} !== 16'h1122) begin
      n_fail++; $display("FAIL rst_regrant: got %b/%h expected %b/1122",
                         flags, {bus.reg_addr, bus.reg_wdata}, F_HOST_WR);
    end
    bus.host_req = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    bus.core_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.core_addr  = 8'(8'h02 + i);
      bus.core_wdata = 8'(8'hD0 + i);
      step();
      n_tests++;
      if (flags !== F_CORE || {bus.reg_addr, bus.reg_wdata} !== {8'(8'h02 + i), 8'(8'hD0 + i)}) begin
        n_fail++; $display("FAIL b2b_write %0d: got %b/%h", i, flags, {bus.reg_addr, bus.reg_wdata});
      end
      step();
      n_tests++;
      if (bus.reg_we !== 1'b0 || bus.reg_addr !== 8'(8'h02 + i)) begin
        n_fail++; $display("FAIL b2b_gap %0d: got we=%b addr=%h", i, bus.reg_we, bus.reg_addr);
      end
    end
    // Four core-only grants must not have built up a streak.
    bus.host_req  = 1'b1;
    bus.host_addr = 8'h50;
    step();
    n_tests++;
    if (flags !== F_CORE) begin
      n_fail++; $display("FAIL streak_cleared: got %b expected %b", flags, F_CORE);
    end
    bus.core_req = 1'b0;
    step();
    step();
    n_tests++;
    if (flags !== F_HOST_WR) begin
      n_fail++; $display("FAIL streak_host_after: got %b expected %b", flags, F_HOST_WR);
    end
    bus.host_req = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_host_only();
    test_lock();
    test_contention();
    test_simultaneous();
    test_rst_in_write();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
